mem_mod_sel_rcvr: RTL and testbench
===================================

# mem_mod_sel_rcvr

Memory-module-side receiver for the module/sector select lines produced by the memory module/register/sector serializer. One instance sits in each core memory module. Each cycle in the select window it decodes the active-low module strobes (MZON/MTTN/MFFN/MSSN) and sector strobes (IMAN/IMBN/DMAN/DMBN). When its own module is addressed, it latches the sector, fetches the word from the core-array model and shifts it out serially, LSB first, on bit-time strobes. It then holds a core-restore interval before it can be selected again.

## Interface
- MODULE_ID, 0: module served by this instance. 0=MZON, 1=MTTN, 2=MFFN, 3=MSSN.
- WORD_BITS, 28: serial word length (26 data + 2 parity).
- RESTORE_CYCLES, 4: clocks of core restore after the last bit.
- SIM_CLK  in  1  sole clock, all state on rising edge.
- SIM_RST  in  1  asynchronous, active-low reset.
- V4MOD6  in  1  select-window qualifier; strobes are sampled only while high.
- MZON, MTTN, MFFN, MSSN  in  1 each  active-low module selects.
- IMAN, IMBN, DMAN, DMBN  in  1 each  active-low sector-half selects.
- BIT_STB  in  1  one-clock pulse per serial bit time.
- RD_ACK  in  1  RD_WORD valid this cycle.
- RD_WORD  in  WORD_BITS  word from the core array at SECT.
- RD_REQ  out  1  one-clock array read request.
- SECT  out  2  latched sector: bit1 = data (D*) vs instruction (I*), bit0 = half B.
- SER_OUT  out  1  serial data bit.
- SER_VAL  out  1  one-clock qualifier for SER_OUT.
- BUSY  out  1  high in every state except IDLE.
- SEL_ERR  out  1  one-clock pulse on an illegal or overlapping select.

## Operation
- States: IDLE, FETCH, SHIFT, RESTORE.
- Reset values: state IDLE; RD_REQ, SECT, SER_OUT, SER_VAL, BUSY, SEL_ERR all 0; shift register and counters 0.
- Decode applies in every cycle with V4MOD6=1:
  - own = the strobe indexed by MODULE_ID is low.
  - mcount = number of module strobes low.
  - scount = number of sector strobes low.
- IDLE, V4MOD6=1:
  - own and mcount=1 and scount=1: latch SECT (IMAN→00, IMBN→01, DMAN→10, DMBN→11), go to FETCH.
  - own and (mcount>1 or scount≠1): SEL_ERR pulse, stay in IDLE.
  - mcount>1 without own: SEL_ERR pulse (bus fault is visible to every module).
  - not own, mcount≤1: no action.
- FETCH: RD_REQ=1 only in the first FETCH cycle. RD_ACK is sampled in every FETCH cycle, including the first. On ack, load the shift register from RD_WORD, clear the bit counter, go to SHIFT. No timeout; the state waits indefinitely.
- SHIFT, on each BIT_STB:
  - SER_OUT ← sreg[0], SER_VAL ← 1 (registered), sreg shifts right with 0 fill, counter increments.
  - On the WORD_BITS-th strobe go to RESTORE.
  - SER_VAL returns to 0 in the cycle after each strobe. SER_OUT holds its value until the next strobe.
- RESTORE: count RESTORE_CYCLES clocks, then go to IDLE. SER_OUT is cleared on entry to IDLE.
- Any select with own=1 while BUSY: SEL_ERR pulse; the current operation continues unchanged.
- BIT_STB outside SHIFT and RD_ACK outside FETCH are ignored.
- Reset asserted mid-operation: immediate return to IDLE with reset values, no partial restore.

## Timing
- Accepting select sampled at edge T. FETCH, BUSY=1 and RD_REQ=1 from T+1. SECT valid from T+1 and held until the next accept.
- RD_ACK at edge A: SHIFT from A+1.
- Strobe k (k=1..WORD_BITS) at edge S_k: SER_OUT = RD_WORD[k-1] and SER_VAL=1 during cycle S_k+1.
- Last strobe at edge L: RESTORE from L+1, IDLE from L+1+RESTORE_CYCLES. A new select can be accepted at that edge.
- Minimum accept-to-accept spacing: 2 + WORD_BITS strobe intervals + RESTORE_CYCLES clocks.

## Structure
- Shared package lvdc_mem_pkg:
  - state enum;
  - sector encoding constants (SECT_IA=0, SECT_IB=1, SECT_DA=2, SECT_DB=3);
  - module index constants.
- One sub-module, mem_sel_decode: combinational strobe decode producing own, mcount>1 and sector code with a legal flag.
- FSM, shift register and counters stay in the top level.

## Test plan
- MODULE_ID=2, V4MOD6=1, MFFN=0, DMBN=0, others high; RD_ACK two cycles later, RD_WORD=28'h0A5F00D -> SECT=11, one RD_REQ pulse; 28 SER_VAL pulses carry bits 1,0,1,1,0,0,0,0,... (LSB first); BUSY falls 4 clocks after the last strobe.
- MZON=0 and MFFN=0 together with IMAN=0 -> SEL_ERR pulse on every instance, no RD_REQ, BUSY stays 0.
- Own module selected, IMAN=0 and DMAN=0 -> SEL_ERR pulse, stays in IDLE.
- Own select re-issued during SHIFT after bit 10 -> SEL_ERR pulse; the remaining 18 bits are unchanged.
- SIM_RST low during SHIFT after bit 5 -> all outputs 0 immediately. After release, a fresh select with IMBN=0 gives SECT=01 and a full 28-bit read.
- RD_ACK high in the same cycle as RD_REQ -> SHIFT entered the next cycle; BIT_STB with no select pending produces no SER_VAL.

Source files
------------

// File: rtl/lvdc_mem_pkg.sv
// Shared definitions for the core memory module select receivers.
package lvdc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_RESTORE
  } mem_state_e;

  localparam logic [1:0] SECT_IA = 2'd0;
  localparam logic [1:0] SECT_IB = 2'd1;
  localparam logic [1:0] SECT_DA = 2'd2;
  localparam logic [1:0] SECT_DB = 2'd3;

  localparam int unsigned MOD_MZON = 0;
  localparam int unsigned MOD_MTTN = 1;
  localparam int unsigned MOD_MFFN = 2;
  localparam int unsigned MOD_MSSN = 3;

endpackage

// File: rtl/mem_sel_decode.sv
// Combinational decode of the active-low module and sector strobes.
module mem_sel_decode
  import lvdc_mem_pkg::*;
#(
  parameter int unsigned MODULE_ID = MOD_MZON
) (
  input  logic [3:0] mod_n,
  input  logic [3:0] sec_n,
  output logic       own_c,
  output logic       multi_c,
  output logic [1:0] sect_c,
  output logic       sect_ok_c
);

  localparam logic [1:0] OWN_IDX = 2'(MODULE_ID);

  logic [2:0] mcount;
  logic [2:0] scount;

  // Sector index follows strobe order IMAN, IMBN, DMAN, DMBN.
  always_comb begin
    mcount = '0;
    scount = '0;
    sect_c = SECT_IA;
    for (int i = 0; i < 4; i++) begin
      mcount = mcount + 3'(!mod_n[i]);
      if (!sec_n[i]) begin
        scount = scount + 3'd1;
        sect_c = 2'(i);
      end
    end
  end

  assign own_c     = !mod_n[OWN_IDX];
  assign multi_c   = mcount > 3'd1;
  assign sect_ok_c = scount == 3'd1;

endmodule

// File: rtl/mem_mod_sel_rcvr.sv
// Memory-module select receiver: decodes module/sector strobes, fetches the
// addressed word and shifts it out LSB first, then waits out core restore.
module mem_mod_sel_rcvr
  import lvdc_mem_pkg::*;
#(
  parameter int unsigned MODULE_ID      = MOD_MZON,
  parameter int unsigned WORD_BITS      = 28,
  parameter int unsigned RESTORE_CYCLES = 4
) (
  input  logic                 SIM_CLK,
  input  logic                 SIM_RST,
  input  logic                 V4MOD6,
  input  logic                 MZON,
  input  logic                 MTTN,
  input  logic                 MFFN,
  input  logic                 MSSN,
  input  logic                 IMAN,
  input  logic                 IMBN,
  input  logic                 DMAN,
  input  logic                 DMBN,
  input  logic                 BIT_STB,
  input  logic                 RD_ACK,
  input  logic [WORD_BITS-1:0] RD_WORD,
  output logic                 RD_REQ,
  output logic [1:0]           SECT,
  output logic                 SER_OUT,
  output logic                 SER_VAL,
  output logic                 BUSY,
  output logic                 SEL_ERR
);

  localparam int unsigned CNT_W = $clog2(WORD_BITS + 1);
  localparam int unsigned RST_W = (RESTORE_CYCLES > 1) ? $clog2(RESTORE_CYCLES) : 1;

  mem_state_e           state;
  logic [WORD_BITS-1:0] sreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic [RST_W-1:0]     rst_cnt;

  logic       own_c;
  logic       multi_c;
  logic [1:0] sect_c;
  logic       sect_ok_c;
  logic       accept_c;
  logic       err_c;

  mem_sel_decode #(.MODULE_ID(MODULE_ID)) u_decode (
    .mod_n     ({MSSN, MFFN, MTTN, MZON}),
    .sec_n     ({DMBN, DMAN, IMBN, IMAN}),
    .own_c     (own_c),
    .multi_c   (multi_c),
    .sect_c    (sect_c),
    .sect_ok_c (sect_ok_c)
  );

  // A bus-wide multi-module select is a fault for every listener.
  assign accept_c = V4MOD6 && own_c && !multi_c && sect_ok_c && (state == ST_IDLE);
  assign err_c    = V4MOD6 && (multi_c || (own_c && ((state != ST_IDLE) || !sect_ok_c)));

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state   <= ST_IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      rst_cnt <= '0;
      RD_REQ  <= 1'b0;
      SECT    <= '0;
      SER_OUT <= 1'b0;
      SER_VAL <= 1'b0;
      BUSY    <= 1'b0;
      SEL_ERR <= 1'b0;
    end else begin
      RD_REQ  <= 1'b0;
      SER_VAL <= 1'b0;
      SEL_ERR <= err_c;
      unique case (state)
        ST_IDLE: begin
          if (accept_c) begin
            SECT   <= sect_c;
            RD_REQ <= 1'b1;
            BUSY   <= 1'b1;
            state  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (RD_ACK) begin
            sreg    <= RD_WORD;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (BIT_STB) begin
            SER_OUT <= sreg[0];
            SER_VAL <= 1'b1;
            sreg    <= {1'b0, sreg[WORD_BITS-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(WORD_BITS - 1)) begin
              rst_cnt <= '0;
              state   <= ST_RESTORE;
            end
          end
        end
        ST_RESTORE: begin
          if (rst_cnt == RST_W'(RESTORE_CYCLES - 1)) begin
            SER_OUT <= 1'b0;
            BUSY    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_mod_sel_rcvr.sv
// Bench for mem_mod_sel_rcvr: per-cycle transaction model plus directed checks.
module tb_mem_mod_sel_rcvr;
  import lvdc_mem_pkg::*;

  localparam int unsigned WB  = 28;
  localparam int unsigned RC  = 4;
  localparam int unsigned OWN = MOD_MFFN;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          v4;
  logic [3:0]    mod_n;
  logic [3:0]    sec_n;
  logic          bit_stb;
  logic          rd_ack;
  logic [WB-1:0] rd_word;
  logic          rd_req;
  logic [1:0]    sect;
  logic          ser_out;
  logic          ser_val;
  logic          busy;
  logic          sel_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_mod_sel_rcvr #(.MODULE_ID(OWN), .WORD_BITS(WB), .RESTORE_CYCLES(RC)) dut (
    .SIM_CLK (clk),
    .SIM_RST (rst_n),
    .V4MOD6  (v4),
    .MZON    (mod_n[0]),
    .MTTN    (mod_n[1]),
    .MFFN    (mod_n[2]),
    .MSSN    (mod_n[3]),
    .IMAN    (sec_n[0]),
    .IMBN    (sec_n[1]),
    .DMAN    (sec_n[2]),
    .DMBN    (sec_n[3]),
    .BIT_STB (bit_stb),
    .RD_ACK  (rd_ack),
    .RD_WORD (rd_word),
    .RD_REQ  (rd_req),
    .SECT    (sect),
    .SER_OUT (ser_out),
    .SER_VAL (ser_val),
    .BUSY    (busy),
    .SEL_ERR (sel_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: pending bits in a queue, a cooldown countdown.
  int   m_mode;
  int   cool;
  bit   q[$];
  logic e_req, e_out, e_val, e_busy, e_err;
  logic [1:0] e_sect;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; cool = 0; q.delete();
      e_req = 0; e_sect = 0; e_out = 0; e_val = 0; e_busy = 0; e_err = 0;
    end else begin
      int  nmod, nsec;
      bit  own;
      nmod  = $countones(~mod_n);
      nsec  = $countones(~sec_n);
      own   = !mod_n[OWN];
      e_err = v4 && (nmod > 1 || (own && (m_mode != 0 || nsec != 1)));
      e_req = 0;
      e_val = 0;
      case (m_mode)
        0: if (v4 && own && nmod == 1 && nsec == 1) begin
             for (int i = 0; i < 4; i++) if (!sec_n[i]) e_sect = 2'(i);
             e_req  = 1;
             m_mode = 1;
           end
        1: if (rd_ack) begin
             for (int i = 0; i < WB; i++) q.push_back(rd_word[i]);
             m_mode = 2;
           end
        2: if (bit_stb) begin
             e_out = q.pop_front();
             e_val = 1;
             if (q.size() == 0) begin m_mode = 3; cool = RC; end
           end
        default: begin
             cool--;
             if (cool == 0) begin m_mode = 0; e_out = 0; end
           end
      endcase
      e_busy = (m_mode != 0);
    end
  end

  always @(negedge clk) begin
    check("rd_req",  32'(rd_req),  32'(e_req));
    check("sect",    32'(sect),    32'(e_sect));
    check("ser_out", 32'(ser_out), 32'(e_out));
    check("ser_val", 32'(ser_val), 32'(e_val));
    check("busy",    32'(busy),    32'(e_busy));
    check("sel_err", 32'(sel_err), 32'(e_err));
  end

  // Capture of the serial stream and pulse counts for the literal checks.
  logic [WB-1:0] cap;
  int val_cnt, req_cnt, err_cnt;

  always @(negedge clk) begin
    if (ser_val) begin cap = {ser_out, cap[WB-1:1]}; val_cnt++; end
    if (rd_req)  req_cnt++;
    if (sel_err) err_cnt++;
  end

  task automatic clr();
    cap = '0; val_cnt = 0; req_cnt = 0; err_cnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sel(input logic [3:0] m, input logic [3:0] s);
    v4 = 1'b1; mod_n = m; sec_n = s;
    tick(1);
    v4 = 1'b0; mod_n = 4'hF; sec_n = 4'hF;
  endtask

  task automatic ack(input logic [WB-1:0] w);
    rd_ack = 1'b1; rd_word = w;
    tick(1);
    rd_ack = 1'b0;
  endtask

  task automatic send_bits(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick(gap);
      bit_stb = 1'b1;
      tick(1);
      bit_stb = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; v4 = 1'b0; mod_n = 4'hF; sec_n = 4'hF;
    bit_stb = 1'b0; rd_ack = 1'b0; rd_word = '0;
    clr();
    tick(2);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sect", 32'(sect), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Basic read of DMBN sector with ack two cycles after the request.
    clr();
    sel(4'b1011, 4'b0111);
    check("t1_sect", 32'(sect), 32'd3);
    check("t1_req",  32'(rd_req), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    tick(1);
    ack(28'h0A5F00D);
    send_bits(WB, 1);
    tick(3);
    check("t1_busy_restore", 32'(busy), 32'd1);
    tick(1);
    check("t1_busy_fall", 32'(busy), 32'd0);
    tick(2);
    check("t1_word", 32'(cap), 32'h0A5F00D);
    check("t1_low4", 32'(cap[3:0]), 32'hD);
    check("t1_nval", 32'(val_cnt), 32'd28);
    check("t1_nreq", 32'(req_cnt), 32'd1);

    // Two module strobes at once: bus fault, no fetch.
    clr();
    sel(4'b1010, 4'b1110);
    check("t2_err",  32'(sel_err), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    tick(3);
    check("t2_nreq", 32'(req_cnt), 32'd0);

    // Own select without window qualifier is ignored.
    mod_n = 4'b1011; sec_n = 4'b1110;
    tick(2);
    mod_n = 4'hF; sec_n = 4'hF;
    check("t2b_busy", 32'(busy), 32'd0);

    // Two sector strobes with own module: error, stays idle.
    clr();
    sel(4'b1011, 4'b1010);
    check("t3_err",  32'(sel_err), 32'd1);
    tick(2);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_nerr", 32'(err_cnt), 32'd1);

    // Own select during SHIFT: error pulse, stream unaffected.
    clr();
    sel(4'b1011, 4'b1110);
    check("t4_sect", 32'(sect), 32'd0);
    ack(28'h9C31E57);
    send_bits(10, 1);
    sel(4'b1011, 4'b1101);
    check("t4_err",  32'(sel_err), 32'd1);
    check("t4_sect_hold", 32'(sect), 32'd0);
    send_bits(18, 2);
    tick(RC + 2);
    check("t4_word", 32'(cap), 32'h9C31E57);
    check("t4_nval", 32'(val_cnt), 32'd28);

    // Reset mid-SHIFT, then a fresh IMBN read.
    clr();
    sel(4'b1011, 4'b0111);
    ack(28'hFFFFFFF);
    send_bits(5, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_out",  32'(ser_out), 32'd0);
    check("t5_rst_sect", 32'(sect), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clr();
    sel(4'b1011, 4'b1101);
    check("t5_sect", 32'(sect), 32'd1);
    ack(28'h5A5A5A5);
    send_bits(WB, 0);
    tick(RC + 2);
    check("t5_word", 32'(cap), 32'h5A5A5A5);
    check("t5_nval", 32'(val_cnt), 32'd28);

    // Ack coincident with RD_REQ, strobe right after; idle strobes do nothing.
    clr();
    sel(4'b1011, 4'b1011);
    check("t6_sect", 32'(sect), 32'd2);
    ack(28'hFFF0001);
    bit_stb = 1'b1;
    tick(1);
    bit_stb = 1'b0;
    check("t6_first_val", 32'(ser_val), 32'd1);
    check("t6_first_bit", 32'(ser_out), 32'd1);
    send_bits(WB - 1, 1);
    tick(RC + 2);
    check("t6_word", 32'(cap), 32'hFFF0001);
    clr();
    send_bits(3, 1);
    tick(2);
    check("t6_idle_nval", 32'(val_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
